// File: rtl/io_serdes_cfg_init_pkg.sv
// rtl/io_serdes_cfg_init_pkg.sv - shared encodings and constants for the SerDes config bring-up block
// Holds the controller state encoding, the CTRL register offset and its
// RXEN/TXEN bit positions, and the two values written during bring-up.
package io_serdes_cfg_init_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_RX     = 3'd1,
        GAP       = 3'd2,
        WR_TX     = 3'd3,
        RD_VERIFY = 3'd4,
        CMD_WR    = 3'd5,
        CMD_RD    = 3'd6
    } state_t;

    localparam int unsigned CTRL_ADDR   = 0;
    localparam int          RXEN_BIT    = 0;
    localparam int          TXEN_BIT    = 1;
    localparam logic [31:0] BOOT_RX_VAL = 32'h1;
    localparam logic [31:0] BOOT_TX_VAL = 32'h3;

    // Bring-up is good only when both enables read back as set.
    function automatic logic ctrl_ok(input logic [1:0] v);
        return v[RXEN_BIT] && v[TXEN_BIT];
    endfunction

endpackage

// File: rtl/io_serdes_axil_xfer.sv
// rtl/io_serdes_axil_xfer.sv - one AXI-Lite write or read with a cycle timeout
// Ports: clk/rst_n (async active-low); start/cmd_* launch a transfer;
// busy spans first valid through completion; done/timeout are single-cycle
// combinational strobes in the completion (or expiry) cycle; rd_data is the
// read data and is meaningful together with done on a read; axi_* master side.
module io_serdes_axil_xfer #(
    parameter int pADDR_WIDTH = 15,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cmd_write,
    input  logic [pADDR_WIDTH-1:0]   cmd_addr,
    input  logic [pDATA_WIDTH-1:0]   cmd_wdata,
    input  logic [pDATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [pDATA_WIDTH-1:0]   rd_data,
    output logic                     axi_awvalid,
    output logic [pADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                     axi_awready,
    output logic                     axi_wvalid,
    output logic [pDATA_WIDTH-1:0]   axi_wdata,
    output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                     axi_wready,
    output logic                     axi_arvalid,
    output logic [pADDR_WIDTH-1:0]   axi_araddr,
    input  logic                     axi_arready,
    input  logic                     axi_rvalid,
    input  logic [pDATA_WIDTH-1:0]   axi_rdata,
    output logic                     axi_rready
);

    localparam int CW = ($clog2(pTIMEOUT + 1) > 8) ? $clog2(pTIMEOUT + 1) : 8;

    logic          is_wr;
    logic          aw_done;
    logic          w_done;
    logic [CW-1:0] cnt;
    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          wr_fin;
    logic          rd_fin;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    // A write finishes once both channels have been accepted, in either order
    // or in the same cycle.
    assign wr_fin  = is_wr && (aw_done || aw_hs) && (w_done || w_hs);
    assign rd_fin  = !is_wr && axi_rvalid && axi_rready;
    assign done    = busy && (wr_fin || rd_fin);
    // cnt is 0 in the first valid cycle, so this fires in the pTIMEOUT-th one.
    assign timeout = busy && !done && (cnt == CW'(pTIMEOUT - 1));
    assign rd_data = axi_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            is_wr       <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cnt         <= '0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_wvalid  <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            axi_rready  <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            is_wr   <= cmd_write;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
            if (cmd_write) begin
                axi_awvalid <= 1'b1;
                axi_awaddr  <= cmd_addr;
                axi_wvalid  <= 1'b1;
                axi_wdata   <= cmd_wdata;
                axi_wstrb   <= cmd_wstrb;
            end else begin
                axi_arvalid <= 1'b1;
                axi_araddr  <= cmd_addr;
            end
        end else if (done || timeout) begin
            busy        <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (aw_hs) begin
                axi_awvalid <= 1'b0;
                aw_done     <= 1'b1;
            end
            if (w_hs) begin
                axi_wvalid <= 1'b0;
                w_done     <= 1'b1;
            end
            if (ar_hs) begin
                axi_arvalid <= 1'b0;
                axi_rready  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_serdes_cfg_init.sv
// rtl/io_serdes_cfg_init.sv - SerDes CTRL bring-up sequencer with host register pass-through
// Ports: axi_clk/axi_reset_n (async active-low); boot_start/boot_done/boot_err
// bring-up control and sticky status; req_*/rsp_* host register access;
// cc_is_enable high while an AXI-Lite transfer is outstanding; axi_* master.
module io_serdes_cfg_init
    import io_serdes_cfg_init_pkg::*;
#(
    parameter int pADDR_WIDTH = 15,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255,
    parameter int pRX_TX_GAP  = 16
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     boot_start,
    output logic                     boot_done,
    output logic                     boot_err,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [pADDR_WIDTH-1:0]   req_addr,
    input  logic [pDATA_WIDTH-1:0]   req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [pDATA_WIDTH-1:0]   rsp_rdata,
    output logic                     rsp_err,
    output logic                     cc_is_enable,
    output logic                     axi_awvalid,
    output logic [pADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                     axi_awready,
    output logic                     axi_wvalid,
    output logic [pDATA_WIDTH-1:0]   axi_wdata,
    output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                     axi_wready,
    output logic                     axi_arvalid,
    output logic [pADDR_WIDTH-1:0]   axi_araddr,
    input  logic                     axi_arready,
    input  logic                     axi_rvalid,
    input  logic [pDATA_WIDTH-1:0]   axi_rdata,
    output logic                     axi_rready
);

    localparam int GW = (pRX_TX_GAP > 1) ? $clog2(pRX_TX_GAP) : 1;

    state_t                   state;
    state_t                   state_nx;
    logic [GW-1:0]            gap_cnt;
    logic [pADDR_WIDTH-1:0]   cmd_addr_q;
    logic [pDATA_WIDTH-1:0]   cmd_wdata_q;
    logic                     ready_c;
    logic                     xfer_start;
    logic                     xfer_write;
    logic [pADDR_WIDTH-1:0]   xfer_addr;
    logic [pDATA_WIDTH-1:0]   xfer_wdata;
    logic                     xfer_busy;
    logic                     xfer_done;
    logic                     xfer_timeout;
    logic [pDATA_WIDTH-1:0]   xfer_rdata;

    // Gated by reset so req_ready reads 0 while reset is held, even though
    // the state register already sits in IDLE.
    assign req_ready = ready_c && axi_reset_n;

    always_comb begin
        state_nx   = state;
        ready_c    = 1'b0;
        xfer_start = 1'b0;
        xfer_write = 1'b0;
        xfer_addr  = pADDR_WIDTH'(CTRL_ADDR);
        xfer_wdata = '0;
        case (state)
            IDLE: begin
                if (boot_start) begin
                    state_nx = WR_RX;
                end else if (req_valid) begin
                    ready_c  = 1'b1;
                    state_nx = req_write ? CMD_WR : CMD_RD;
                end
            end
            WR_RX: begin
                // Launch only in the entry cycle; busy then covers the rest.
                xfer_start = !xfer_busy;
                xfer_write = 1'b1;
                xfer_wdata = pDATA_WIDTH'(BOOT_RX_VAL);
                if (xfer_done)         state_nx = GAP;
                else if (xfer_timeout) state_nx = IDLE;
            end
            GAP: begin
                if (gap_cnt == GW'(pRX_TX_GAP - 1)) state_nx = WR_TX;
            end
            WR_TX: begin
                xfer_start = !xfer_busy;
                xfer_write = 1'b1;
                xfer_wdata = pDATA_WIDTH'(BOOT_TX_VAL);
                if (xfer_done)         state_nx = RD_VERIFY;
                else if (xfer_timeout) state_nx = IDLE;
            end
            RD_VERIFY: begin
                xfer_start = !xfer_busy;
                if (xfer_done || xfer_timeout) state_nx = IDLE;
            end
            CMD_WR: begin
                xfer_start = !xfer_busy;
                xfer_write = 1'b1;
                xfer_addr  = cmd_addr_q;
                xfer_wdata = cmd_wdata_q;
                if (xfer_done || xfer_timeout) state_nx = IDLE;
            end
            CMD_RD: begin
                xfer_start = !xfer_busy;
                xfer_addr  = cmd_addr_q;
                if (xfer_done || xfer_timeout) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            boot_done   <= 1'b0;
            boot_err    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state     <= state_nx;
            gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (req_valid && ready_c) begin
                cmd_addr_q  <= req_addr;
                cmd_wdata_q <= req_wdata;
            end
            case (state)
                IDLE: begin
                    if (boot_start) begin
                        boot_done <= 1'b0;
                        boot_err  <= 1'b0;
                    end
                end
                WR_RX, WR_TX: begin
                    if (xfer_timeout) boot_err <= 1'b1;
                end
                RD_VERIFY: begin
                    if (xfer_done) begin
                        if (ctrl_ok(xfer_rdata[1:0])) boot_done <= 1'b1;
                        else                          boot_err  <= 1'b1;
                    end else if (xfer_timeout) begin
                        boot_err <= 1'b1;
                    end
                end
                CMD_WR, CMD_RD: begin
                    if (xfer_done || xfer_timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= xfer_timeout;
                        if (state == CMD_RD && xfer_done) rsp_rdata <= xfer_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    io_serdes_axil_xfer #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH),
        .pTIMEOUT    (pTIMEOUT)
    ) u_xfer (
        .clk         (axi_clk),
        .rst_n       (axi_reset_n),
        .start       (xfer_start),
        .cmd_write   (xfer_write),
        .cmd_addr    (xfer_addr),
        .cmd_wdata   (xfer_wdata),
        .cmd_wstrb   ({(pDATA_WIDTH/8){1'b1}}),
        .busy        (xfer_busy),
        .done        (xfer_done),
        .timeout     (xfer_timeout),
        .rd_data     (xfer_rdata),
        .axi_awvalid (axi_awvalid),
        .axi_awaddr  (axi_awaddr),
        .axi_awready (axi_awready),
        .axi_wvalid  (axi_wvalid),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wready  (axi_wready),
        .axi_arvalid (axi_arvalid),
        .axi_araddr  (axi_araddr),
        .axi_arready (axi_arready),
        .axi_rvalid  (axi_rvalid),
        .axi_rdata   (axi_rdata),
        .axi_rready  (axi_rready)
    );

    assign cc_is_enable = xfer_busy;

endmodule

// File: tb/tb_io_serdes_cfg_init.sv
// tb/tb_io_serdes_cfg_init.sv - self-checking bench for io_serdes_cfg_init
module tb_io_serdes_cfg_init;

    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int TO  = 255;
    localparam int GAP = 16;

    logic          axi_clk = 1'b0;
    logic          axi_reset_n = 1'b0;
    logic          boot_start = 1'b0;
    logic          boot_done, boot_err;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_err, cc_is_enable;
    logic [DW-1:0] rsp_rdata;
    logic          axi_awvalid, axi_awready = 1'b0;
    logic [AW-1:0] axi_awaddr;
    logic          axi_wvalid, axi_wready = 1'b0;
    logic [DW-1:0] axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_arvalid, axi_arready = 1'b0;
    logic [AW-1:0] axi_araddr;
    logic          axi_rvalid = 1'b0, axi_rready;
    logic [DW-1:0] axi_rdata = '0;

    always #5 axi_clk = ~axi_clk;

    io_serdes_cfg_init #(
        .pADDR_WIDTH (AW), .pDATA_WIDTH (DW), .pTIMEOUT (TO), .pRX_TX_GAP (GAP)
    ) dut (
        .axi_clk (axi_clk), .axi_reset_n (axi_reset_n),
        .boot_start (boot_start), .boot_done (boot_done), .boot_err (boot_err),
        .req_valid (req_valid), .req_write (req_write), .req_addr (req_addr),
        .req_wdata (req_wdata), .req_ready (req_ready),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .cc_is_enable (cc_is_enable),
        .axi_awvalid (axi_awvalid), .axi_awaddr (axi_awaddr), .axi_awready (axi_awready),
        .axi_wvalid (axi_wvalid), .axi_wdata (axi_wdata), .axi_wstrb (axi_wstrb),
        .axi_wready (axi_wready),
        .axi_arvalid (axi_arvalid), .axi_araddr (axi_araddr), .axi_arready (axi_arready),
        .axi_rvalid (axi_rvalid), .axi_rdata (axi_rdata), .axi_rready (axi_rready)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    s;
    } wr_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        int            aw_lat;
        int            w_lat;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    wr_t  exp_wr_q[$];
    rsp_t exp_rsp_q[$];

    // responder knobs and state
    int            aw_lat = 0, w_lat = 0;
    bit            ar_never = 0, rd_force = 0;
    logic [DW-1:0] rd_force_val = '0;
    logic [DW-1:0] mem [16];
    int            aw_wait = 0, w_wait = 0;
    bit            got_aw = 0, got_w = 0, rd_pend = 0, r_hs_sched = 0;
    wr_t           cap;
    logic [AW-1:0] cap_araddr = '0;

    // monitor state
    int  aw_hs_cnt = 0, w_hs_cnt = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;
    int  idle_run = 0, cc_viol = 0, stab_viol = 0, rsp_cnt = 0;
    int  gaps[$];
    bit  p_aw = 0, p_w = 0, p_ar = 0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [3:0]    p_wstrb = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI-Lite responder; decides readies at negedge so handshakes land on the next posedge
    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_rvalid = 0;
            got_aw = 0; got_w = 0; rd_pend = 0; r_hs_sched = 0; aw_wait = 0; w_wait = 0;
        end else begin
            axi_awready = axi_awvalid && (aw_wait >= aw_lat);
            if (axi_awvalid && !axi_awready) aw_wait++; else aw_wait = 0;
            if (axi_awready) begin got_aw = 1; cap.a = axi_awaddr; aw_hs_cnt++; end
            axi_wready = axi_wvalid && (w_wait >= w_lat);
            if (axi_wvalid && !axi_wready) w_wait++; else w_wait = 0;
            if (axi_wready) begin got_w = 1; cap.d = axi_wdata; cap.s = axi_wstrb; w_hs_cnt++; end
            if (got_aw && got_w) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 128'(cap), 0);
                else chk("wr_txn", 128'(cap), 128'(exp_wr_q.pop_front()));
                mem[cap.a[5:2]] = cap.d;
                got_aw = 0; got_w = 0;
            end
            if (r_hs_sched) begin axi_rvalid = 0; r_hs_sched = 0; end
            if (rd_pend) begin
                axi_rvalid = 1;
                axi_rdata  = rd_force ? rd_force_val : mem[cap_araddr[5:2]];
                rd_pend    = 0;
            end
            axi_arready = axi_arvalid && !ar_never;
            if (axi_arready) begin rd_pend = 1; cap_araddr = axi_araddr; end
            if (axi_rvalid && axi_rready) r_hs_sched = 1;
        end
    end

    // response scoreboard and protocol monitor
    always @(negedge axi_clk) begin
        if (axi_reset_n) begin
            logic any;
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", {rsp_rdata, rsp_err}, 0);
                else chk("rsp", {rsp_rdata, rsp_err}, 128'(exp_rsp_q.pop_front()));
            end
            if (axi_awvalid) aw_hi++;
            if (axi_wvalid)  w_hi++;
            if (axi_arvalid) ar_hi++;
            any = axi_awvalid | axi_wvalid | axi_arvalid | axi_rready;
            if (any !== cc_is_enable) cc_viol++;
            if (axi_awvalid && !p_aw) gaps.push_back(idle_run);
            idle_run = any ? 0 : idle_run + 1;
            if (p_aw && axi_awvalid && axi_awaddr !== p_awaddr) stab_viol++;
            if (p_w && axi_wvalid && {axi_wdata, axi_wstrb} !== {p_wdata, p_wstrb}) stab_viol++;
            if (p_ar && axi_arvalid && axi_araddr !== p_araddr) stab_viol++;
            p_aw = axi_awvalid; p_w = axi_wvalid; p_ar = axi_arvalid;
            p_awaddr = axi_awaddr; p_wdata = axi_wdata; p_wstrb = axi_wstrb; p_araddr = axi_araddr;
        end
    end

    task automatic host_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] exp_rd, input bit exp_err, output int waited);
        wr_t w;
        w.a = a; w.d = d; w.s = 4'hF;
        if (wr && !exp_err) exp_wr_q.push_back(w);
        exp_rsp_q.push_back({wr ? '0 : exp_rd, exp_err});
        @(negedge axi_clk);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
        waited = 0;
        #1;
        while (!req_ready && waited < 1000) begin
            @(negedge axi_clk); #1; waited++;
        end
        if (!req_ready) chk("req_accept", 0, 1);
        else begin @(posedge axi_clk); #1; end
        req_valid = 0;
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget && exp_rsp_q.size() != 0; i++) begin
            @(negedge axi_clk); #2;
        end
        if (exp_rsp_q.size() != 0) begin
            chk("rsp_timeout", 128'(exp_rsp_q.size()), 0);
            exp_rsp_q.delete();
        end
    endtask

    task automatic push_boot_writes();
        wr_t w;
        w.a = '0; w.s = 4'hF;
        w.d = 32'h1; exp_wr_q.push_back(w);
        w.d = 32'h3; exp_wr_q.push_back(w);
    endtask

    task automatic wait_boot();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge axi_clk); #1;
            if (boot_done || boot_err) ok = 1;
        end
        if (!ok) chk("boot_finish", 0, 1);
    endtask

    task automatic run_boot();
        push_boot_writes();
        @(negedge axi_clk); boot_start = 1;
        @(negedge axi_clk); boot_start = 0;
        wait_boot();
    endtask

    function automatic logic [127:0] all_outs();
        return {boot_done, boot_err, req_ready, rsp_valid, rsp_rdata, rsp_err, cc_is_enable,
                axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
                axi_arvalid, axi_araddr, axi_rready};
    endfunction

    vec_t vt[8];

    initial begin
        int waited;
        int g;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        vt[0] = '{1'b1, 15'h04, 32'hA5A5_0001, 32'h0, 0, 0};
        vt[1] = '{1'b1, 15'h08, 32'h1234_5678, 32'h0, 2, 0};
        vt[2] = '{1'b0, 15'h04, 32'h0, 32'hA5A5_0001, 0, 0};
        vt[3] = '{1'b0, 15'h08, 32'h0, 32'h1234_5678, 0, 0};
        vt[4] = '{1'b1, 15'h04, 32'hDEAD_BEEF, 32'h0, 1, 1};
        vt[5] = '{1'b0, 15'h04, 32'h0, 32'hDEAD_BEEF, 0, 0};
        vt[6] = '{1'b0, 15'h3C, 32'h0, 32'h0, 0, 0};
        vt[7] = '{1'b0, 15'h00, 32'h0, 32'h3, 0, 0};

        // reset state
        repeat (3) @(negedge axi_clk);
        #1 chk("reset_outputs", all_outs(), 0);
        @(negedge axi_clk); axi_reset_n = 1;

        // nominal bring-up: 0x1, gap, 0x3, read-back 0x3
        gaps.delete();
        run_boot();
        chk("boot_ok_done", boot_done, 1);
        chk("boot_ok_err", boot_err, 0);
        // GAP cycles plus the WR_TX entry cycle separate the two writes
        g = (gaps.size() >= 2) ? gaps[1] : -1;
        chk("rx_tx_gap", 128'(g), 128'(GAP + 1));

        // host command table
        for (int i = 0; i < 8; i++) begin
            aw_lat = vt[i].aw_lat; w_lat = vt[i].w_lat;
            host_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, 1'b0, waited);
            wait_rsp(100);
        end
        aw_lat = 0; w_lat = 0;

        // address accepted three cycles ahead of data
        w_lat = 3;
        @(negedge axi_clk); #2;
        aw_hi = 0; w_hi = 0; aw_hs_cnt = 0; w_hs_cnt = 0;
        host_req(1'b1, 15'h20, 32'hCAFE_0020, '0, 1'b0, waited);
        wait_rsp(100);
        chk("split_aw_cycles", 128'(aw_hi), 1);
        chk("split_w_cycles", 128'(w_hi), 4);
        chk("split_aw_count", 128'(aw_hs_cnt), 1);
        chk("split_w_count", 128'(w_hs_cnt), 1);
        w_lat = 0;
        host_req(1'b0, 15'h20, '0, 32'hCAFE_0020, 1'b0, waited);
        wait_rsp(100);

        // read-back shows only RXEN
        rd_force = 1; rd_force_val = 32'h1;
        run_boot();
        chk("boot_bad_done", boot_done, 0);
        chk("boot_bad_err", boot_err, 1);
        rd_force = 0;

        // read never accepted -> timeout
        ar_never = 1;
        @(negedge axi_clk); #2; ar_hi = 0;
        host_req(1'b0, 15'h00, '0, '0, 1'b1, waited);
        wait_rsp(TO + 100);
        chk("timeout_ar_cycles", 128'(ar_hi), 128'(TO));
        @(negedge axi_clk); #1 chk("timeout_arvalid_low", axi_arvalid, 0);
        ar_never = 0;

        // boot_start and host request arrive together
        push_boot_writes();
        begin
            wr_t w;
            w.a = 15'h24; w.d = 32'h0BAD_F00D; w.s = 4'hF;
            exp_wr_q.push_back(w);
            exp_rsp_q.push_back({32'h0, 1'b0});
        end
        @(negedge axi_clk);
        boot_start = 1; req_valid = 1; req_write = 1; req_addr = 15'h24; req_wdata = 32'h0BAD_F00D;
        #1 chk("race_req_ready", req_ready, 0);
        @(negedge axi_clk); boot_start = 0;
        waited = 0;
        #1;
        while (!req_ready && waited < 2000) begin
            @(negedge axi_clk); #1; waited++;
        end
        chk("race_boot_first", boot_done, 1);
        chk("race_wait_long", 128'(waited > GAP), 1);
        if (req_ready) begin @(posedge axi_clk); #1; end
        req_valid = 0;
        wait_rsp(100);

        // reset while the TXEN write is outstanding
        aw_lat = 6;
        gaps.delete();
        begin
            wr_t w;
            w.a = '0; w.d = 32'h1; w.s = 4'hF;
            exp_wr_q.push_back(w);
        end
        @(negedge axi_clk); boot_start = 1;
        @(negedge axi_clk); boot_start = 0;
        for (int i = 0; i < 500 && gaps.size() < 2; i++) @(negedge axi_clk);
        chk("wr_tx_reached", 128'(gaps.size() >= 2), 1);
        @(negedge axi_clk);
        axi_reset_n = 0;
        #1 chk("midreset_outputs", all_outs(), 0);
        @(negedge axi_clk); @(negedge axi_clk);
        axi_reset_n = 1;
        aw_lat = 0;
        chk("midreset_wr_queue", 128'(exp_wr_q.size()), 0);
        waited = rsp_cnt;
        repeat (20) @(negedge axi_clk);
        #1 chk("midreset_no_rsp", 128'(rsp_cnt - waited), 0);
        host_req(1'b0, 15'h04, '0, 32'hDEAD_BEEF, 1'b0, waited);
        chk("midreset_idle", 128'(waited), 0);
        wait_rsp(100);

        // closing checks
        repeat (5) @(negedge axi_clk);
        chk("wr_queue_empty", 128'(exp_wr_q.size()), 0);
        chk("rsp_queue_empty", 128'(exp_rsp_q.size()), 0);
        chk("cc_is_enable_track", 128'(cc_viol), 0);
        chk("payload_stable", 128'(stab_viol), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_serdes_cfg_init.md
IO_SERDES_CFG_INIT -- requirements
Module: io_serdes_cfg_init

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 15, the AXI-Lite byte-address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, the AXI-Lite data width.
REQ-003 SHALL have parameter pTIMEOUT, default 255, the maximum cycles a transaction may wait (8-bit counter minimum).
REQ-004 SHALL have parameter pRX_TX_GAP, default 16, the idle cycles between the rxen write and the txen write.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: axi_clk  in  1  sole clock; axi_reset_n  in  1  async active-low reset.
REQ-006 SHALL have these ports:
- boot_start  in  1  one-cycle pulse; starts the bring-up sequence
- boot_done  out  1  sticky; sequence verified OK
- boot_err  out  1  sticky; sequence timed out or read-back mismatched
- req_valid  in  1  host register request valid
- req_write  in  1  1=write, 0=read
- req_addr  in  pADDR_WIDTH  host byte address
- req_wdata  in  pDATA_WIDTH  host write data
- req_ready  out  1  request accepted this cycle
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  pDATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  valid with rsp_valid; timeout
- cc_is_enable  out  1  high while any AXI-Lite transaction is outstanding
- axi_awvalid/axi_awaddr[pADDR_WIDTH]/axi_awready (in)  write address channel
- axi_wvalid/axi_wdata[pDATA_WIDTH]/axi_wstrb[pDATA_WIDTH/8]/axi_wready (in)  write data channel
- axi_arvalid/axi_araddr[pADDR_WIDTH]/axi_arready (in)  read address channel
- axi_rvalid (in)/axi_rdata (in)[pDATA_WIDTH]/axi_rready  read data channel

Function
REQ-007 SHALL implement states IDLE, WR_RX, GAP, WR_TX, RD_VERIFY, CMD_WR, CMD_RD.
REQ-008 IDLE: boot_start -> WR_RX and clear boot_done/boot_err; otherwise req_valid -> CMD_WR or CMD_RD per req_write.
REQ-009 req_ready SHALL be 1 only in IDLE, with req_valid=1 and boot_start=0; boot_start wins simultaneous arrival.
REQ-010 Host request fields SHALL be captured on req_valid&&req_ready.
REQ-011 WR_RX SHALL write address 0, data 0x1, wstrb 0xF; on completion -> GAP.
REQ-012 GAP SHALL count exactly pRX_TX_GAP cycles, then -> WR_TX.
REQ-013 WR_TX SHALL write address 0, data 0x3, wstrb 0xF; on completion -> RD_VERIFY.
REQ-014 RD_VERIFY SHALL read address 0; rdata[1:0]==2'b11 sets boot_done, otherwise boot_err; -> IDLE.
REQ-015 Write transaction: awvalid and wvalid asserted the cycle after state entry; each channel's valid drops the cycle after its own ready is sampled; awready and wready in different cycles SHALL be accepted; complete when both are accepted.
REQ-016 Read transaction: arvalid held until arready; rready=1 from the cycle after arready until rvalid; capture rdata on rvalid&&rready; complete there.
REQ-017 axi_awaddr, axi_wdata, axi_wstrb and axi_araddr SHALL be stable while the corresponding valid is high.
REQ-018 cc_is_enable SHALL be 1 from first valid assertion through the completion cycle, 0 otherwise.
REQ-019 The timeout counter SHALL restart at each transaction start; at pTIMEOUT cycles without completion, drop all valids/rready and go -> IDLE; boot sets boot_err, command pulses rsp_valid with rsp_err=1.
REQ-020 CMD_WR/CMD_RD completion SHALL pulse rsp_valid for one cycle, with rsp_err=0, one cycle after completion, then -> IDLE.
REQ-021 boot_start outside IDLE SHALL be ignored.

Reset
REQ-022 Reset asserted SHALL force state to IDLE and all outputs to 0, including every valid, rready, address, data, strobe, boot_done, boot_err, rsp_*, req_ready and cc_is_enable.
REQ-023 Reset mid-transaction SHALL drop valids immediately, asynchronously, with no response pulse after release.

Structure
REQ-024 A shared package SHALL hold state encoding, CTRL register offset 0, bit positions RXEN=0/TXEN=1, and the boot values 0x1/0x3.
REQ-025 A single sub-module, io_serdes_axil_xfer, SHALL implement one AXI-Lite write or read with timeout; the FSM sequences it.

Verification
REQ-026 Scenario: responder with immediate ready, boot_start -> writes 0x1 then exactly 16 gap cycles then 0x3, read returns 0x3, boot_done=1.
REQ-027 Scenario: awready 3 cycles before wready -> awvalid drops after acceptance, wvalid held, single completion, no duplicate write.
REQ-028 Scenario: read-back returns 0x1 -> boot_err=1, boot_done=0.
REQ-029 Scenario: responder never asserts arready, host read 0x0 -> rsp_valid with rsp_err=1 after 255 cycles, arvalid low afterwards.
REQ-030 Scenario: boot_start and req_valid same cycle -> boot runs, req_ready=0 until IDLE, then the request is served.
REQ-031 Scenario: reset during WR_TX -> all outputs 0, state IDLE, no rsp_valid.
